// File: rtl/regfile_write_ctrl_if.sv
// Write-back request / register-file write bus for regfile_write_ctrl.
// master = WB stage and read-port side, slave = the write controller.
interface regfile_write_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             hold;
  logic [31:0]      reg_en;
  logic [WIDTH-1:0] reg_din;
  logic [4:0]       rd_addr;
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;
  logic [CW-1:0]    count;

  modport master (
    output wr_valid, wr_addr, wr_data, hold, rd_addr,
    input  wr_ready, reg_en, reg_din, fwd_hit, fwd_data, count
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, hold, rd_addr,
    output wr_ready, reg_en, reg_din, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register-file write controller: FIFO-buffered write-back requests drained as
// a registered one-hot write enable, with forwarding of pending writes.
module regfile_write_ctrl #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_write_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_reg_en;
  logic [WIDTH-1:0] r_reg_din;
  logic [4:0]       r_out_addr;

  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic [4:0]       w_head_addr;
  logic [PW-1:0]    w_idx;
  logic             w_fwd_hit;
  logic [WIDTH-1:0] w_fwd_data;

  assign w_ready     = (r_count < CW'(DEPTH));
  assign w_push      = bus.wr_valid && w_ready;
  assign w_pop       = (r_count != '0) && !bus.hold;
  assign w_head_addr = r_addr[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_reg_en   <= '0;
      r_reg_din  <= '0;
      r_out_addr <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_wptr] <= bus.wr_addr;
        r_data[r_wptr] <= bus.wr_data;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + 1'b1;
        r_reg_en   <= (w_head_addr == 5'd31) ? '0 : (32'd1 << w_head_addr);
        r_reg_din  <= r_data[r_rptr];
        r_out_addr <= w_head_addr;
      end else begin
        r_reg_en <= '0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match overwrites; output stage has lowest priority.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    if (bus.rd_addr != 5'd31) begin
      if ((r_reg_en != '0) && (r_out_addr == bus.rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_reg_din;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        w_idx = r_rptr + PW'(k);
        if ((CW'(k) < r_count) && (r_addr[w_idx] == bus.rd_addr)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = r_data[w_idx];
        end
      end
    end
  end

  assign bus.wr_ready = w_ready;
  assign bus.reg_en   = r_reg_en;
  assign bus.reg_din  = r_reg_din;
  assign bus.fwd_hit  = w_fwd_hit;
  assign bus.fwd_data = w_fwd_data;
  assign bus.count    = r_count;
endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Write-side counterpart of the register file's 32:1 read-select path.
- Accepts write-back requests from the WB stage through a valid/ready handshake and buffers them in a small FIFO.
- Drains one request per cycle as a registered one-hot 32-bit write enable plus data to the 32 register storage elements.
- Provides a combinational forwarding lookup so reads can see writes still pending in this block. X31 (XZR) writes are accepted and discarded.

Parameters:
- WIDTH, 64, data width of each register.
- DEPTH, 2, FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  request can be accepted this cycle.
- wr_addr  input  5  destination register number.
- wr_data  input  WIDTH  write data.
- hold  input  1  register file busy; pauses draining.
- reg_en  output  32  one-hot write enable; bit i writes register i.
- reg_din  output  WIDTH  data for the enabled register.
- rd_addr  input  5  register being read, for the forwarding check.
- fwd_hit  output  1  rd_addr has a pending write in this block.
- fwd_data  output  WIDTH  youngest pending data for rd_addr.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, reg_en=0, reg_din=0, read and write pointers=0, all entries invalid.
  - Takes effect immediately, including mid-drain. An in-flight reg_en is cleared at once.
- Handshake:
  - wr_ready = (count < DEPTH). It is a pure function of state and does not depend on hold or wr_valid.
  - A push occurs when wr_valid && wr_ready at the clock edge.
  - Requests with wr_valid=0 are ignored. wr_addr and wr_data are don't-care when wr_valid=0.
- Push: the entry {addr, data} is written at the write pointer. The write pointer increments modulo DEPTH.
- Pop:
  - Occurs when count>0 && !hold.
  - The head entry is registered into the output stage and the read pointer increments modulo DEPTH.
  - reg_en <= (head.addr==31) ? 0 : (1 << head.addr). reg_din <= head.data.
- No pop: reg_en <= 0 and reg_din holds its previous value.
- reg_en is never multi-hot. It is nonzero for exactly one cycle per accepted non-X31 request.
- Latency: a request accepted at edge N into an empty FIFO with hold=0 drives reg_en at edge N+1. It is visible during cycle N+1 and the register file captures it at edge N+2.
- Simultaneous push and pop: both occur and count is unchanged.
  - Push and pop are allowed together only when count<DEPTH.
  - When full, a same-cycle pop does not make wr_ready high. The new request waits one cycle.
- Ordering: strict FIFO. Two writes to the same register drain in arrival order.
- hold: freezes the FIFO head and forces reg_en=0 the next cycle. Pushes continue until full.
- Forwarding (combinational):
  - Search the valid FIFO entries from youngest to oldest, then the output stage when reg_en is nonzero.
  - The first entry with addr==rd_addr gives fwd_hit=1 and fwd_data=that entry's data.
  - rd_addr==31 always gives fwd_hit=0 and fwd_data=0.
  - With no match, fwd_hit=0 and fwd_data=0.
  - Same-cycle push data on the wr_* inputs is not forwarded.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap silently. count alone distinguishes full from empty.

Test Plan:
- Reset then single write: wr_addr=5, wr_data=0xDEAD_BEEF with hold=0 → reg_en=32'h0000_0020 and reg_din=0xDEADBEEF for exactly one cycle, one cycle after the accept edge. count returns to 0.
- X31 drop: write addr=31, data=0x1234 → accepted (wr_ready=1), reg_en stays 0 every cycle, count returns to 0. rd_addr=31 gives fwd_hit=0.
- Fill with hold=1 (DEPTH=2): push addr 1 then addr 2 → count=2, wr_ready=0, reg_en=0. A third request stalls. Release hold → reg_en=0x2, then 0x4, then the third request's enable on consecutive cycles.
- Same-register ordering and forwarding: with hold=1, push addr 7 data=A then addr 7 data=B; rd_addr=7 → fwd_hit=1, fwd_data=B. Release hold → reg_din=A then B.
- Simultaneous push/pop at count=1, hold=0: count stays 1 and the data drains in order with no loss.
- Asynchronous reset asserted mid-cycle while count=2 and reg_en nonzero: reg_en=0 and count=0 immediately, before the next edge. After release, no stale writes appear.
